// File: rtl/dvi_line_fetcher.sv
// dvi_line_fetcher
// Feeds the DVI drawer one line chunk at a time. Each chunk is read from frame
// memory as a burst of single-word requests (one outstanding at a time),
// assembled MSB-first into a wide buffer and handed over with a one-cycle
// ram_ack. The word address walks the frame linearly and wraps at the frame
// end; new_frame rewinds it to the frame base.
module dvi_line_fetcher #(
    parameter int WORD_W          = 32,
    parameter int LINE_BITS       = 6144,
    parameter int WORDS_PER_CHUNK = LINE_BITS / WORD_W,
    parameter int ADDR_W          = 20,
    parameter int BASE_ADDR       = 0,
    parameter int FRAME_WORDS     = 786432
) (
    input  logic                 pixel_clock,
    input  logic                 reset,
    input  logic                 mem_ready,
    input  logic                 new_frame,
    input  logic                 ask_data,
    output logic                 ram_init,
    output logic                 ram_ack,
    output logic [LINE_BITS-1:0] read_data,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_rd_gnt,
    input  logic                 mem_rd_valid,
    input  logic [WORD_W-1:0]    mem_rd_data
);

    localparam int CNT_W = (WORDS_PER_CHUNK > 1) ? $clog2(WORDS_PER_CHUNK) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_CHUNK - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   pending_r;
    logic                   ram_init_r;
    logic                   ram_ack_r;
    logic                   mem_rd_en_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [CNT_W-1:0]       word_cnt_r;
    logic [LINE_BITS-1:0]   chunk_buf_r;
    logic [LINE_BITS-1:0]   read_data_r;
    logic [LINE_BITS-1:0]   chunk_next_s;
    logic                   start_fetch_s;
    logic                   take_word_s;
    logic                   last_word_s;

    assign ram_init  = ram_init_r;
    assign ram_ack   = ram_ack_r;
    assign read_data = read_data_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_addr  = addr_r;

    // Next-state logic and per-cycle fetch events; new_frame has top priority.
    always_comb begin
        next_state_s  = state_r;
        start_fetch_s = 1'b0;
        take_word_s   = 1'b0;
        last_word_s   = 1'b0;
        chunk_next_s  = {chunk_buf_r[LINE_BITS-WORD_W-1:0], mem_rd_data};
        case (state_r)
            ST_IDLE: begin
                if (new_frame) begin
                    next_state_s = ST_IDLE;
                end else if (pending_r && ram_init_r) begin
                    next_state_s  = ST_REQ;
                    start_fetch_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (new_frame) begin
                    // A request granted in this very cycle will still return data.
                    next_state_s = mem_rd_gnt ? ST_DRAIN : ST_IDLE;
                end else if (mem_rd_gnt) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rd_valid) begin
                    if (new_frame) begin
                        // Read completed alongside the frame restart: discard it.
                        next_state_s = ST_IDLE;
                    end else begin
                        take_word_s  = 1'b1;
                        last_word_s  = (word_cnt_r == LAST_CNT);
                        next_state_s = (word_cnt_r == LAST_CNT) ? ST_DONE : ST_REQ;
                    end
                end else if (new_frame) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mem_rd_valid) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky memory-usable flag, set the cycle after mem_ready is seen.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            ram_init_r <= 1'b0;
        end else if (mem_ready) begin
            ram_init_r <= 1'b1;
        end else begin
            ram_init_r <= ram_init_r;
        end
    end

    // Pending chunk request; repeated asks collapse into one.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (new_frame) begin
            pending_r <= 1'b0;
        end else if (start_fetch_s) begin
            pending_r <= 1'b0;
        end else if (ask_data) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Frame word address: advances per accepted word, wraps at frame end.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            addr_r <= BASE;
        end else if (new_frame) begin
            addr_r <= BASE;
        end else if (take_word_s) begin
            addr_r <= (addr_r == LAST_ADDR) ? BASE : (addr_r + ADDR_W'(1));
        end else begin
            addr_r <= addr_r;
        end
    end

    // Word counter within the current chunk.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            word_cnt_r <= '0;
        end else if (start_fetch_s) begin
            word_cnt_r <= '0;
        end else if (take_word_s) begin
            word_cnt_r <= word_cnt_r + CNT_W'(1);
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    // Assembly buffer: shift left one word, newest word at the LSBs.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            chunk_buf_r <= '0;
        end else if (take_word_s) begin
            chunk_buf_r <= chunk_next_s;
        end else begin
            chunk_buf_r <= chunk_buf_r;
        end
    end

    // Output chunk and ack, updated together on the edge after the last word.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            read_data_r <= '0;
            ram_ack_r   <= 1'b0;
        end else if (take_word_s && last_word_s) begin
            read_data_r <= chunk_next_s;
            ram_ack_r   <= 1'b1;
        end else begin
            read_data_r <= read_data_r;
            ram_ack_r   <= 1'b0;
        end
    end

    // Read request, high for exactly the cycles spent in REQ.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            mem_rd_en_r <= 1'b0;
        end else begin
            mem_rd_en_r <= (next_state_s == ST_REQ);
        end
    end

endmodule

// File: tb/tb_dvi_line_fetcher.sv
// tb_dvi_line_fetcher
// Directed bench for dvi_line_fetcher with a small frame (384 words) so the
// address wrap is reached. Memory model: data = address, immediate grant,
// read data returned three cycles after the grant.
module tb_dvi_line_fetcher;

    localparam int WORD_W    = 32;
    localparam int LINE_BITS = 6144;
    localparam int ADDR_W    = 20;
    localparam int FRAME     = 384;
    localparam int CHUNK     = 192;

    logic                 pixel_clock = 1'b0;
    logic                 reset;
    logic                 mem_ready;
    logic                 new_frame;
    logic                 ask_data;
    logic                 ram_init;
    logic                 ram_ack;
    logic [LINE_BITS-1:0] read_data;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rd_gnt;
    logic                 mem_rd_valid;
    logic [WORD_W-1:0]    mem_rd_data;

    logic                 inj_valid = 1'b0;
    logic [2:0]           v_pipe = 3'b000;
    logic [ADDR_W-1:0]    a0 = '0;
    logic [ADDR_W-1:0]    a1 = '0;
    logic [ADDR_W-1:0]    a2 = '0;

    int cmp_cnt = 0;
    int fail_cnt = 0;
    int ack_cnt = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int last_valid_cyc = 0;
    int addr_q[$];

    dvi_line_fetcher #(
        .WORD_W(WORD_W), .LINE_BITS(LINE_BITS), .WORDS_PER_CHUNK(CHUNK),
        .ADDR_W(ADDR_W), .BASE_ADDR(0), .FRAME_WORDS(FRAME)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .mem_ready   (mem_ready),
        .new_frame   (new_frame),
        .ask_data    (ask_data),
        .ram_init    (ram_init),
        .ram_ack     (ram_ack),
        .read_data   (read_data),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_gnt  (mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data)
    );

    always #5 pixel_clock = ~pixel_clock;

    assign mem_rd_gnt   = mem_rd_en;
    assign mem_rd_valid = v_pipe[2] | inj_valid;
    assign mem_rd_data  = inj_valid ? 32'hDEAD_BEEF : {12'd0, a2};

    // Memory model: return data three cycles after each grant.
    always @(posedge pixel_clock) begin
        v_pipe <= {v_pipe[1:0], mem_rd_en & mem_rd_gnt};
        a0 <= mem_addr;
        a1 <= a0;
        a2 <= a1;
    end

    // Monitor: log granted addresses, last valid cycle and acks.
    always @(posedge pixel_clock) begin
        if (mem_rd_en && mem_rd_gnt) addr_q.push_back(int'(mem_addr));
        if (mem_rd_valid) last_valid_cyc = cyc;
        if (ram_ack) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Number of logged addresses that deviate from a contiguous wrapping run.
    function automatic int gaps(input int from, input int n, input int first);
        int e = first;
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (addr_q.size() <= from + i) bad++;
            else if (addr_q[from + i] != e) bad++;
            e = (e + 1) % FRAME;
        end
        return bad;
    endfunction

    task automatic pulse_ask();
        @(negedge pixel_clock) ask_data = 1'b1;
        @(negedge pixel_clock) ask_data = 1'b0;
    endtask

    task automatic wait_acks(input int target, input string tag);
        int n = 0;
        while (ack_cnt < target && n < 3000) begin
            @(negedge pixel_clock);
            n++;
        end
        check(tag, 64'(ack_cnt), 64'(target));
    endtask

    initial begin
        int n;
        reset = 1'b1; mem_ready = 1'b0; new_frame = 1'b0; ask_data = 1'b0;

        // Reset with no clock edge yet.
        #2;
        check("rst_ram_init", 64'(ram_init), 64'd0);
        check("rst_ram_ack", 64'(ram_ack), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_rdata_top", 64'(read_data[LINE_BITS-1 -: WORD_W]), 64'd0);

        @(negedge pixel_clock);
        @(negedge pixel_clock);
        reset = 1'b0;

        // Ask before the memory is ready: held pending.
        pulse_ask();
        repeat (5) @(negedge pixel_clock);
        check("pre_init_ram_init", 64'(ram_init), 64'd0);
        check("pre_init_no_req", 64'(mem_rd_en), 64'd0);
        mem_ready = 1'b1;
        @(posedge pixel_clock); #1;
        check("ram_init_rise", 64'(ram_init), 64'd1);
        check("no_req_same_cycle", 64'(mem_rd_en), 64'd0);
        @(posedge pixel_clock); #1;
        check("held_ask_start", 64'(mem_rd_en), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);

        // Two asks during the first fetch collapse into one extra fetch.
        repeat (100) @(negedge pixel_clock);
        pulse_ask();
        repeat (100) @(negedge pixel_clock);
        pulse_ask();
        wait_acks(1, "ack1_seen");
        check("c1_top", 64'(read_data[LINE_BITS-1 -: WORD_W]), 64'd0);
        check("c1_word100", 64'(read_data[LINE_BITS-1-100*WORD_W -: WORD_W]), 64'd100);
        check("c1_low", 64'(read_data[WORD_W-1:0]), 64'd191);
        check("c1_nreq", 64'(addr_q.size()), 64'd192);
        check("c1_contig", 64'(gaps(0, CHUNK, 0)), 64'd0);
        check("c1_ack_latency", 64'(ack_cyc - last_valid_cyc), 64'd1);

        // Second chunk runs from the pending ask; old data held meanwhile.
        repeat (300) @(negedge pixel_clock);
        check("c2_hold_top", 64'(read_data[LINE_BITS-1 -: WORD_W]), 64'd0);
        check("c2_hold_low", 64'(read_data[WORD_W-1:0]), 64'd191);
        wait_acks(2, "ack2_seen");
        check("c2_top", 64'(read_data[LINE_BITS-1 -: WORD_W]), 64'd192);
        check("c2_low", 64'(read_data[WORD_W-1:0]), 64'd383);
        check("c2_contig", 64'(gaps(192, CHUNK, 192)), 64'd0);
        repeat (30) @(negedge pixel_clock);
        check("collapse_acks", 64'(ack_cnt), 64'd2);
        check("collapse_nreq", 64'(addr_q.size()), 64'd384);
        check("collapse_idle", 64'(mem_rd_en), 64'd0);

        // Stray valid while idle is ignored.
        @(negedge pixel_clock) inj_valid = 1'b1;
        @(negedge pixel_clock) inj_valid = 1'b0;
        repeat (5) @(negedge pixel_clock);
        check("stray_no_ack", 64'(ack_cnt), 64'd2);

        // Third chunk wraps to the start of the 384-word frame.
        pulse_ask();
        wait_acks(3, "ack3_seen");
        check("c3_top", 64'(read_data[LINE_BITS-1 -: WORD_W]), 64'd0);
        check("c3_low", 64'(read_data[WORD_W-1:0]), 64'd191);
        check("c3_contig", 64'(gaps(384, CHUNK, 0)), 64'd0);

        // new_frame during the wait for word 50 of the fourth chunk.
        pulse_ask();
        n = 0;
        while (addr_q.size() < 576 + 51 && n < 1000) begin
            @(negedge pixel_clock);
            n++;
        end
        check("c4_reach_w50", 64'(addr_q.size()), 64'd627);
        check("c4_contig", 64'(gaps(576, 51, 192)), 64'd0);
        new_frame = 1'b1;
        @(negedge pixel_clock) new_frame = 1'b0;
        repeat (30) @(negedge pixel_clock);
        check("nf_no_ack", 64'(ack_cnt), 64'd3);
        check("nf_idle", 64'(mem_rd_en), 64'd0);
        check("nf_nreq", 64'(addr_q.size()), 64'd627);
        check("nf_rdata_kept", 64'(read_data[WORD_W-1:0]), 64'd191);

        // Next fetch restarts at frame base.
        pulse_ask();
        wait_acks(4, "ack4_seen");
        check("c5_contig", 64'(gaps(627, CHUNK, 0)), 64'd0);
        check("c5_low", 64'(read_data[WORD_W-1:0]), 64'd191);

        // Asynchronous reset in the middle of a fetch.
        pulse_ask();
        repeat (40) @(negedge pixel_clock);
        #2 reset = 1'b1;
        #1;
        check("arst_rd_en", 64'(mem_rd_en), 64'd0);
        check("arst_ram_init", 64'(ram_init), 64'd0);
        check("arst_addr", 64'(mem_addr), 64'd0);
        check("arst_rdata_low", 64'(read_data[WORD_W-1:0]), 64'd0);
        @(negedge pixel_clock) reset = 1'b0;
        repeat (5) @(negedge pixel_clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
